// File: rtl/rom_fetch_if.sv
// Bus between the ROM burst fetcher and its environment (requester, ROM, consumer).
interface rom_fetch_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  // Fetcher side: drives the ROM address and the output word stream.
  modport master (
    input  start_i, base_i, len_i, data_i, ready_i,
    output addr_o, data_o, valid_o, busy_o, done_o, error_o
  );

  // Environment side: issues bursts, models the ROM, consumes words.
  modport slave (
    output start_i, base_i, len_i, data_i, ready_i,
    input  addr_o, data_o, valid_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/rom_fetch.sv
// Burst reader for a combinational ROM with a one-word valid/ready output slot.
module rom_fetch #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORDS      = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  rom_fetch_if.master bus
);
  localparam int unsigned RW = ADDR_WIDTH + 1;
  localparam logic [RW-1:0] WORDS_EXT = RW'(WORDS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  valid_q, valid_nxt;
  logic [RW-1:0]         rem_q, rem_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  error_q, error_nxt;

  logic [RW-1:0] addr_inc;
  logic [RW-1:0] rem_dec;
  logic [RW-1:0] base_ext;
  logic          free_slot;
  logic          handshake;

  // Range checks run one bit wider so a wrap of addr_o+1 reads as out of range.
  always_comb begin
    addr_inc  = {1'b0, addr_q} + RW'(1);
    rem_dec   = rem_q - RW'(1);
    base_ext  = {1'b0, bus.base_i};
    free_slot = !valid_q || bus.ready_i;
    handshake = valid_q && bus.ready_i;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    rem_nxt   = rem_q;
    done_nxt  = 1'b0;
    error_nxt = error_q;
    busy_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) valid_nxt = 1'b0;
        if (bus.start_i) begin
          if (base_ext >= WORDS_EXT) begin
            error_nxt = 1'b1;
            done_nxt  = 1'b1;
          end else if (bus.len_i == '0) begin
            error_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt  = bus.base_i;
            rem_nxt   = bus.len_i;
            error_nxt = 1'b0;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        if (free_slot) begin
          data_nxt  = bus.data_i;
          valid_nxt = 1'b1;
          addr_nxt  = addr_inc[ADDR_WIDTH-1:0];
          rem_nxt   = rem_dec;
          if (rem_dec == '0) begin
            state_nxt = DRAIN;
          end else if (addr_inc >= WORDS_EXT) begin
            error_nxt = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (free_slot) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      rem_q   <= rem_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      error_q <= error_nxt;
    end
  end

  assign bus.addr_o  = addr_q;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.error_o = error_q;
endmodule

// File: doc/rom_fetch.md
ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, ROM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, ROM address width in bits.
REQ-003 SHALL have parameter WORDS, default 5, number of valid ROM words; legal addresses are 0..WORDS-1.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port start_i, input, 1, burst request; sampled only in IDLE.
REQ-007 SHALL have port base_i, input, ADDR_WIDTH, burst start address; sampled with start_i.
REQ-008 SHALL have port len_i, input, ADDR_WIDTH+1, burst word count; sampled with start_i.
REQ-009 SHALL have port addr_o, output, ADDR_WIDTH, address driven to the ROM addr_i.
REQ-010 SHALL have port data_i, input, DATA_WIDTH, combinational ROM data_o for addr_o.
REQ-011 SHALL have port data_o, output, DATA_WIDTH, registered fetched word.
REQ-012 SHALL have port valid_o, output, 1, data_o holds an unconsumed word.
REQ-013 SHALL have port ready_i, input, 1, consumer accepts data_o when valid_o && ready_i.
REQ-014 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done_o, output, 1, one-cycle pulse at burst end.
REQ-016 SHALL have port error_o, output, 1, sticky out-of-range flag.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN as a registered FSM.
REQ-018 In IDLE, start_i with base_i < WORDS and len_i != 0 SHALL load addr_o=base_i, remaining=len_i, clear error_o, and enter FETCH next cycle.
REQ-019 In IDLE, start_i with len_i == 0 SHALL pulse done_o next cycle, clear error_o, and stay in IDLE.
REQ-020 In IDLE, start_i with base_i >= WORDS SHALL set error_o, pulse done_o next cycle, and stay in IDLE; this rule takes priority over REQ-019.
REQ-021 start_i SHALL be ignored outside IDLE; the burst in progress is unaffected.
REQ-022 In FETCH, the slot is free when !valid_o || ready_i; only on a free-slot cycle SHALL data_o<=data_i, valid_o<=1, addr_o<=addr_o+1, and remaining<=remaining-1.
REQ-023 On a non-free-slot cycle in FETCH, addr_o, data_o and remaining SHALL hold.
REQ-024 The range check SHALL be done at ADDR_WIDTH+1 bits, so addr_o+1 == 2^ADDR_WIDTH counts as out of range.
REQ-025 On a free-slot fetch, if remaining reaches 0, the FSM SHALL enter DRAIN.
REQ-026 On a free-slot fetch, if remaining > 0 but addr_o+1 >= WORDS, the FSM SHALL set error_o, enter DRAIN, and truncate the burst.
REQ-027 In DRAIN, the FSM SHALL fetch nothing; when valid_o && ready_i or !valid_o, it SHALL clear valid_o, pulse done_o next cycle, and return to IDLE.
REQ-028 Outside FETCH, a handshake (valid_o && ready_i) with no refill SHALL clear valid_o.
REQ-029 Latency SHALL be: start_i accepted in cycle N, addr_o=base in N+1, first valid_o in N+2; one word per cycle with ready_i held high.
REQ-030 data_o SHALL remain stable while valid_o && !ready_i.
REQ-031 Exactly len_i handshakes SHALL occur per non-truncated burst; for a truncated burst, exactly WORDS-base_i.

Reset
REQ-032 With rst_i high at an edge, the block SHALL set state=IDLE, addr_o=0, data_o=0, valid_o=0, done_o=0, error_o=0, remaining=0.
REQ-033 Reset mid-burst SHALL abort with no done_o pulse; any pending word is discarded.

Verification
REQ-034 base=1, len=3, ready_i=1 -> addr_o 1,2,3; valid_o for 3 cycles with data_o=rom[1],rom[2],rom[3]; done_o pulses once; error_o=0.
REQ-035 base=0, len=2, ready_i low for 3 cycles after the first valid_o -> data_o stays rom[0] and addr_o stays 1; then rom[1] is delivered; exactly 2 handshakes.
REQ-036 base=3, len=4 (WORDS=5) -> rom[3], rom[4] delivered; error_o=1; done_o pulses; next start with base=0, len=1 clears error_o.
REQ-037 base=5, and separately len=0 -> no valid_o; done_o pulses next cycle; error_o=1 for base=5 only.
REQ-038 rst_i asserted after the 2nd word of a base=0, len=5 burst -> next cycle IDLE with all outputs 0 and no done_o.
REQ-039 start_i pulsed during an active burst -> ignored; the original burst completes with the correct word count.
